// File: rtl/config_int_add_acc_clkgate.sv
// Approximate integer adder/accumulator with a run-time selectable number of gated LSBs and a 2-stage valid/ready pipeline.
// Define CONFIG_INT_ADD_SATURATE_EN to saturate c on signed overflow instead of wrapping.
module config_int_add_acc_clkgate #(
    parameter int DATA_PATH_BITWIDTH = 32,
    parameter int MAX_GATED_BITWIDTH = 16,
    localparam int GW = $clog2(MAX_GATED_BITWIDTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_we,
    input  logic [GW-1:0]                 cfg_gated_bits,
    input  logic                          cfg_mode,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          acc_clr,
    input  logic [DATA_PATH_BITWIDTH-1:0] a,
    input  logic [DATA_PATH_BITWIDTH-1:0] b,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_PATH_BITWIDTH-1:0] c,
    output logic                          c_ovf
);

    localparam int DW  = DATA_PATH_BITWIDTH;
    localparam int MSB = DW - 1;
    localparam logic [DW-1:0] ONES  = '1;
    localparam logic [GW-1:0] G_MAX = GW'(MAX_GATED_BITWIDTH);

    logic [GW-1:0] cfg_g_q;
    logic          cfg_mode_q;
    logic [GW-1:0] cfg_g_clamped;

    logic          s1_valid;
    logic          s1_mode;
    logic          s1_clr;
    logic [GW-1:0] s1_g;
    logic [DW-1:0] s1_a;
    logic [DW-1:0] s1_b;

    logic [DW-1:0] acc_q;

    logic          s2_advance;
    logic          accept;
    logic [DW-1:0] load_en;
    logic [DW-1:0] s2_mask;
    logic [DW-1:0] ma;
    logic [DW-1:0] mb;
    logic [DW-1:0] sum;
    logic [DW-1:0] op_x;
    logic [DW-1:0] op_y;
    logic [DW-1:0] res;
    logic [DW-1:0] c_next;
    logic          ovf;

    assign s2_advance    = !out_valid || out_ready;
    assign in_ready      = !rst && (!s1_valid || s2_advance);
    assign accept        = in_valid && in_ready;
    assign cfg_g_clamped = (cfg_gated_bits > G_MAX) ? G_MAX : cfg_gated_bits;
    // Per-bit load enable for the operand registers: the low g bits stay frozen like a gated clock.
    assign load_en       = ONES << cfg_g_q;

    always_comb begin
        s2_mask = ONES << s1_g;
        ma      = s1_a & s2_mask;
        mb      = s1_b & s2_mask;
        sum     = ma + mb;
        if (s1_mode) begin
            op_x = s1_clr ? '0 : acc_q;
            op_y = sum;
        end else begin
            op_x = ma;
            op_y = mb;
        end
        res = op_x + op_y;
        ovf = (op_x[MSB] == op_y[MSB]) && (res[MSB] != op_x[MSB]);
`ifdef CONFIG_INT_ADD_SATURATE_EN
        if (ovf) begin
            c_next = op_x[MSB] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end else begin
            c_next = res;
        end
`else
        c_next = res;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_g_q    <= '0;
            cfg_mode_q <= 1'b0;
            s1_valid   <= 1'b0;
            s1_mode    <= 1'b0;
            s1_clr     <= 1'b0;
            s1_g       <= '0;
            s1_a       <= '0;
            s1_b       <= '0;
            acc_q      <= '0;
            out_valid  <= 1'b0;
            c          <= '0;
            c_ovf      <= 1'b0;
        end else begin
            if (cfg_we) begin
                cfg_g_q    <= cfg_g_clamped;
                cfg_mode_q <= cfg_mode;
            end

            if (accept) begin
                s1_valid <= 1'b1;
                s1_mode  <= cfg_mode_q;
                s1_clr   <= acc_clr;
                s1_g     <= cfg_g_q;
                s1_a     <= (a & load_en) | (s1_a & ~load_en);
                s1_b     <= (b & load_en) | (s1_b & ~load_en);
            end else if (s2_advance) begin
                s1_valid <= 1'b0;
            end

            if (s1_valid && s2_advance) begin
                out_valid <= 1'b1;
                c         <= c_next;
                c_ovf     <= ovf;
                if (s1_mode) begin
                    acc_q <= c_next;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
